// File: rtl/sw_run_ctrl.sv
// Control sequencer for the MM:SS stopwatch: conditions buttons/switches,
// runs the RUN/HOLD/ADJ machine and drives counter strobes and display blanking.
module sw_run_ctrl #(
  parameter int DB_CYCLES = 500000,
  parameter int DB_W      = 20
) (
  input  logic clk,
  input  logic RESET,
  input  logic btn_pause,
  input  logic btn_clr,
  input  logic sw_adj,
  input  logic sw_sel,
  input  logic tick_1hz,
  input  logic tick_2hz,
  input  logic blink_phase,
  output logic sec_inc,
  output logic min_inc,
  output logic cnt_clr,
  output logic blank_min,
  output logic blank_sec,
  output logic paused
);

  typedef enum logic [1:0] {RUN, HOLD, ADJ} state_t;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  // Bit order: 0 = pause button, 1 = clear button, 2 = adjust, 3 = select.
  logic [3:0] sync1, sync2;
  logic [1:0][DB_W-1:0] db_cnt;
  logic [1:0] db_lvl;
  logic [1:0] press;

  logic pause_p, clr_p, adj_s, sel_s;
  assign pause_p = press[0];
  assign clr_p   = press[1];
  assign adj_s   = sync2[2];
  assign sel_s   = sync2[3];

  state_t state, state_nxt;
  state_t ret_state, ret_nxt;
  logic   sec_d, min_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {sw_sel, sw_adj, btn_clr, btn_pause};
      sync2 <= sync1;
    end
  end

  // Press pulses are registered on the cycle the debounced level rises.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      db_cnt <= '0;
      db_lvl <= '0;
      press  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_lvl[i] <= sync2[i];
          db_cnt[i] <= '0;
          press[i]  <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    ret_nxt   = ret_state;
    case (state)
      RUN: begin
        if (adj_s) begin
          state_nxt = ADJ;
          ret_nxt   = RUN;
        end else if (pause_p) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (adj_s) begin
          state_nxt = ADJ;
          ret_nxt   = HOLD;
        end else if (pause_p) begin
          state_nxt = RUN;
        end
      end
      ADJ: begin
        if (!adj_s) state_nxt = ret_state;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    sec_d = ((state == RUN) && tick_1hz) || ((state == ADJ) && sel_s && tick_2hz);
    min_d = (state == ADJ) && !sel_s && tick_2hz;
    // A clear drops any coinciding tick rather than deferring it.
    if (clr_p) begin
      sec_d = 1'b0;
      min_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state     <= RUN;
      ret_state <= RUN;
      sec_inc   <= 1'b0;
      min_inc   <= 1'b0;
      cnt_clr   <= 1'b0;
      blank_min <= 1'b0;
      blank_sec <= 1'b0;
      paused    <= 1'b0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_nxt;
      sec_inc   <= sec_d;
      min_inc   <= min_d;
      cnt_clr   <= clr_p;
      blank_min <= (state == ADJ) && !sel_s && blink_phase;
      blank_sec <= (state == ADJ) && sel_s && blink_phase;
      paused    <= (state_nxt == HOLD);
    end
  end

endmodule

// File: tb/tb_sw_run_ctrl.sv
// Directed bench for sw_run_ctrl with a short debounce window.
module tb_sw_run_ctrl;

  logic clk = 1'b0;
  logic RESET;
  logic btn_pause, btn_clr, sw_adj, sw_sel;
  logic tick_1hz, tick_2hz, blink_phase;
  logic sec_inc, min_inc, cnt_clr, blank_min, blank_sec, paused;

  int checks   = 0;
  int failures = 0;

  sw_run_ctrl #(.DB_CYCLES(4), .DB_W(3)) dut (
    .clk        (clk),
    .RESET      (RESET),
    .btn_pause  (btn_pause),
    .btn_clr    (btn_clr),
    .sw_adj     (sw_adj),
    .sw_sel     (sw_sel),
    .tick_1hz   (tick_1hz),
    .tick_2hz   (tick_2hz),
    .blink_phase(blink_phase),
    .sec_inc    (sec_inc),
    .min_inc    (min_inc),
    .cnt_clr    (cnt_clr),
    .blank_min  (blank_min),
    .blank_sec  (blank_sec),
    .paused     (paused)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Observed outputs packed as {sec_inc,min_inc,cnt_clr,blank_min,blank_sec,paused}.
  task automatic check_all(input string tag, input logic [5:0] exp);
    check({tag, ".sec_inc"},   sec_inc,   exp[5]);
    check({tag, ".min_inc"},   min_inc,   exp[4]);
    check({tag, ".cnt_clr"},   cnt_clr,   exp[3]);
    check({tag, ".blank_min"}, blank_min, exp[2]);
    check({tag, ".blank_sec"}, blank_sec, exp[1]);
    check({tag, ".paused"},    paused,    exp[0]);
  endtask

  task automatic clean_pause_press();
    btn_pause = 1'b1;
    cyc(10);
    btn_pause = 1'b0;
    cyc(10);
  endtask

  initial begin
    RESET = 1'b1;
    {btn_pause, btn_clr, sw_adj, sw_sel} = '0;
    {tick_1hz, tick_2hz, blink_phase} = '0;
    cyc(2);
    check_all("reset", 6'b000000);
    RESET = 1'b0;
    cyc(3);

    // Free run: tick every 100 cycles, strobe one cycle later and one cycle wide.
    for (int k = 0; k < 3; k++) begin
      tick_1hz = 1'b1;
      cyc();
      tick_1hz = 1'b0;
      check_all("run_tick", 6'b100000);
      cyc();
      check_all("run_after", 6'b000000);
      cyc(98);
    end

    // Bouncing pause press, then held: exactly one toggle into HOLD.
    for (int k = 0; k < 3; k++) begin
      btn_pause = 1'b1;
      cyc();
      btn_pause = 1'b0;
      cyc();
    end
    check("bounce_no_press", paused, 1'b0);
    btn_pause = 1'b1;
    cyc(20);
    check("bounce_hold", paused, 1'b1);
    btn_pause = 1'b0;
    cyc(10);
    check("release_still_hold", paused, 1'b1);
    tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
    check_all("hold_tick", 6'b000001);
    clean_pause_press();
    check("second_press_run", paused, 1'b0);

    // Adjust minutes from HOLD.
    clean_pause_press();
    check("enter_hold", paused, 1'b1);
    sw_adj = 1'b1;
    sw_sel = 1'b0;
    cyc(4);
    check_all("adj_min_idle", 6'b000000);
    tick_2hz = 1'b1;
    cyc();
    tick_2hz = 1'b0;
    check_all("adj_min_tick", 6'b010000);
    cyc();
    check("adj_min_tick_end", min_inc, 1'b0);
    blink_phase = 1'b1;
    cyc();
    check_all("adj_min_blank", 6'b000100);
    blink_phase = 1'b0;
    cyc();
    check("adj_min_unblank", blank_min, 1'b0);
    sw_adj = 1'b0;
    cyc(4);
    check_all("adj_min_exit_hold", 6'b000001);

    // Adjust seconds from RUN.
    clean_pause_press();
    check("back_to_run", paused, 1'b0);
    sw_adj = 1'b1;
    sw_sel = 1'b1;
    cyc(4);
    tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
    check("adj_sec_1hz_ignored", sec_inc, 1'b0);
    tick_2hz = 1'b1;
    cyc();
    tick_2hz = 1'b0;
    check_all("adj_sec_tick", 6'b100000);
    blink_phase = 1'b1;
    cyc();
    check_all("adj_sec_blank", 6'b000010);
    blink_phase = 1'b0;
    sw_adj = 1'b0;
    cyc(4);
    check_all("adj_sec_exit", 6'b000000);

    // Adjust and pause raised together: pause is swallowed in ADJ, exit to RUN.
    sw_adj    = 1'b1;
    btn_pause = 1'b1;
    cyc(10);
    btn_pause = 1'b0;
    cyc(10);
    check("adj_pause_paused", paused, 1'b0);
    sw_adj = 1'b0;
    cyc(4);
    check("adj_pause_exit", paused, 1'b0);
    tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
    check("adj_pause_run_tick", sec_inc, 1'b1);
    cyc(3);

    // Clear press landing on a tick: clear wins, tick dropped, state kept.
    btn_clr = 1'b1;
    cyc(6);
    check("clr_not_yet", cnt_clr, 1'b0);
    tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
    check_all("clr_collide", 6'b001000);
    cyc();
    check_all("clr_one_cycle", 6'b000000);
    cyc(10);
    check("clr_held_once", cnt_clr, 1'b0);
    btn_clr = 1'b0;
    cyc(10);
    tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
    check_all("clr_next_tick", 6'b100000);

    // Asynchronous reset while blanking seconds in ADJ.
    sw_adj      = 1'b1;
    sw_sel      = 1'b1;
    blink_phase = 1'b1;
    cyc(5);
    check("pre_reset_blank_sec", blank_sec, 1'b1);
    #2;
    RESET = 1'b1;
    #1;
    check_all("async_reset", 6'b000000);
    sw_adj      = 1'b0;
    blink_phase = 1'b0;
    cyc(2);
    RESET = 1'b0;
    cyc(3);
    tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
    check_all("post_reset_tick", 6'b100000);

    // Button held across reset is re-debounced from 0 and yields one press.
    btn_pause = 1'b1;
    cyc(10);
    check("held_pre_reset", paused, 1'b1);
    RESET = 1'b1;
    cyc(2);
    check("held_in_reset", paused, 1'b0);
    RESET = 1'b0;
    cyc(10);
    check("held_after_reset", paused, 1'b1);
    btn_pause = 1'b0;
    cyc(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
